// File: rtl/adder_operand_recover.sv
// adder_operand_recover: pipelined b = sum - a with the borrow chain split into STAGE_WIDTH slices.
module adder_operand_recover #(
  parameter int ADDER_WIDTH = 80,
  parameter int STAGE_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH:0]   sum,
  input  logic [ADDER_WIDTH-1:0] a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   underflow,
  output logic                   overflow
);
  localparam int NS = ADDER_WIDTH / STAGE_WIDTH;
  logic [ADDER_WIDTH:0]   s_r [NS+1];
  logic [ADDER_WIDTH-1:0] a_r [NS];
  logic [STAGE_WIDTH:0]   dif [NS];
  logic [NS:0]            br;
  logic [NS:0]            v;
  logic                   en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  // Zero-extended slice subtraction: the extra top bit is the borrow out.
  always_comb
    for (int k = 0; k < NS; k++)
      dif[k] = {1'b0, s_r[k][k*STAGE_WIDTH +: STAGE_WIDTH]} - {1'b0, a_r[k][k*STAGE_WIDTH +: STAGE_WIDTH]}
               - (STAGE_WIDTH+1)'(br[k]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (en) v <= {v[NS-1:0], in_valid};
  // Each stage overwrites its slice of the minuend with the difference slice.
  always_ff @(posedge clk)
    if (en) begin
      s_r[0] <= sum;
      a_r[0] <= a;
      br[0] <= 1'b0;
      for (int k = 1; k <= NS; k++) begin
        s_r[k] <= s_r[k-1];
        s_r[k][(k-1)*STAGE_WIDTH +: STAGE_WIDTH] <= dif[k-1][STAGE_WIDTH-1:0];
        br[k] <= dif[k-1][STAGE_WIDTH];
        if (k < NS) a_r[k] <= a_r[k-1];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      b <= '0;
      underflow <= 1'b0;
      overflow <= 1'b0;
    end else if (en) begin
      out_valid <= v[NS];
      b <= s_r[NS][ADDER_WIDTH-1:0] & {ADDER_WIDTH{v[NS]}};
      underflow <= v[NS] && !s_r[NS][ADDER_WIDTH] && br[NS];
      overflow <= v[NS] && s_r[NS][ADDER_WIDTH] && !br[NS];
    end
endmodule

// File: tb/tb_adder_operand_recover.sv
// tb_adder_operand_recover: vector table plus scoreboard bench for adder_operand_recover.
module tb_adder_operand_recover;
  typedef struct {
    logic [80:0] sum;
    logic [79:0] a;
    logic [79:0] b;
    logic        uf;
    logic        of;
  } vec_t;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [80:0] sum;
  logic [79:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] b;
  logic        underflow;
  logic        overflow;
  int          total = 0;
  int          bad = 0;
  int          run = 0;
  int          maxrun = 0;
  logic        bp_on;
  logic        prev_stall = 0;
  logic [82:0] prev;
  vec_t        sb[$];
  vec_t        tv[11];
  vec_t        rv[10];

  adder_operand_recover dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [80:0] s, input logic [79:0] x, input logic [79:0] y,
                              input logic u, input logic o);
    vec_t r;
    r.sum = s; r.a = x; r.b = y; r.uf = u; r.of = o;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t t);
    logic acc;
    in_valid = 1; sum = t.sum; a = t.a;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(t);
      @(posedge clk); #1;
    end while (!acc);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 81'(sb.size()), 81'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      vec_t e;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (!out_valid) chk("idle_flags", {underflow, overflow}, 2'b00);
      if (prev_stall) chk("stall_hold", {out_valid, underflow, overflow, b}, prev);
      if (out_valid && out_ready) begin
        run++;
        if (run > maxrun) maxrun = run;
        if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          e = sb.pop_front();
          chk("b", b, e.b);
          chk("underflow", underflow, e.uf);
          chk("overflow", overflow, e.of);
        end
      end else run = 0;
      prev_stall = out_valid && !out_ready;
      prev = {out_valid, underflow, overflow, b};
    end
  end

  initial begin
    tv[0]  = mk(81'd1000, 80'd400, 80'd600, 0, 0);
    tv[1]  = mk(81'h10_0000, 80'd1, 80'hF_FFFF, 0, 0);
    tv[2]  = mk(81'h1000_0000_0000_0000, 80'd1, 80'h0FFF_FFFF_FFFF_FFFF, 0, 0);
    tv[3]  = mk(81'd3, 80'd5, 80'hFFFF_FFFF_FFFF_FFFF_FFFE, 1, 0);
    tv[4]  = mk(81'h1_0000_0000_0000_0000_0005, 80'd2, 80'd3, 0, 1);
    tv[5]  = mk(81'h1_0000_0000_0000_0000_0001, 80'd2, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 0, 0);
    tv[6]  = mk(81'd0, 80'd0, 80'd0, 0, 0);
    tv[7]  = mk(81'h0_FFFF_FFFF_FFFF_FFFF_FFFF, 80'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 0, 0);
    tv[8]  = mk(81'd0, 80'd1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1, 0);
    tv[9]  = mk(81'h1_FFFF_FFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'd0, 0, 1);
    tv[10] = mk(81'h1_0000_0000_0000_0000_0000, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'd1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [79:0] x, y;
      x = {$urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom};
      rv[i] = mk({1'b0, x} + {1'b0, y}, x, y, 0, 0);
    end
    rst_n = 0; in_valid = 0; out_ready = 1; sum = '0; a = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_b", b, 80'd0);
    chk("rst_flags", {underflow, overflow}, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    // Latency: result visible after the fifth edge following acceptance.
    send(tv[0]);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      chk("latency", out_valid, j == 5);
    end
    @(posedge clk); #1;
    drain();
    for (int i = 1; i < 11; i++) send(tv[i]);
    drain();
    maxrun = 0;
    for (int i = 0; i < 8; i++) send(tv[i]);
    drain();
    chk("throughput_run", 81'(maxrun), 81'd8);
    bp_on = 1;
    fork
      begin
        int n = 0;
        for (int i = 0; i < 10; i++) send(rv[i]);
        while (sb.size() != 0 && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
        chk("bp_drain", 81'(sb.size()), 81'd0);
        bp_on = 0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(tv[3 + i]);
    rst_n = 0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_b", b, 80'd0);
      chk("post_rst_flags", {underflow, overflow}, 2'b00);
    end
    @(posedge clk); #1;
    send(tv[4]);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_operand_recover.md
Name: adder_operand_recover

Overview:
- Inverse companion of the registered adder benchmark: takes a sum word and one operand, and recovers the other operand as b = sum − a.
- Datapath is a pipelined subtractor whose borrow chain is split into STAGE_WIDTH-bit slices, one slice per register stage.
- Valid/ready handshake on both sides with full backpressure.
- Used as an arithmetic benchmark and as a round-trip checker behind the adder (a + b → sum → b).

Parameters:
- ADDER_WIDTH, 80, operand width W; sum input is W+1 bits.
- STAGE_WIDTH, 20, bits of borrow chain resolved per pipeline stage. Must divide ADDER_WIDTH; NSTAGES = ADDER_WIDTH/STAGE_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- sum  input  ADDER_WIDTH+1  minuend (adder result)
- a  input  ADDER_WIDTH  subtrahend (known operand)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- b  output  ADDER_WIDTH  recovered operand, (sum − a) mod 2^W
- underflow  output  1  sum < a
- overflow  output  1  sum − a ≥ 2^W

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, b, underflow and overflow are 0. in_ready is 1 after reset.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. All stages advance only when en = 1; the stall is global, with no bubble collapsing.
- Beat accepted when in_valid && in_ready.
- Stage 0 registers sum and a, with borrow_in = 0.
- Stage k (1..NSTAGES) computes slice k−1: {borrow_out, d} = sum_slice − a_slice − borrow_in.
  - Registers d, borrow_out, the untouched upper operand bits, and the lower result bits already computed.
- Final stage also resolves the top bit, using s = sum[W] and br = final borrow:
  - s=0, br=0 → no flags.
  - s=0, br=1 → underflow = 1.
  - s=1, br=0 → overflow = 1.
  - s=1, br=1 → no flags (exact fit).
  - b is always the low W bits of the difference.
- Latency: a beat accepted at edge N gives out_valid = 1 after edge N + NSTAGES + 1 (5 with defaults), absent stalls.
- Throughput is one beat per cycle.
- Output holding:
  - While out_valid && !out_ready, b, underflow, overflow and out_valid hold stable, and in_ready = 0.
  - When out_ready is high and no new beat arrives, out_valid drops the cycle after the last beat drains.
- Bubbles: an invalid stage propagates as valid = 0. Data in invalid stages is don't-care, but flags on the outputs must never show a nonzero value while out_valid = 0. Mask the flags with valid or clear them.
- Simultaneous accept and output: in_valid with out_ready both high when the pipe is full → both transfers occur in the same cycle.
- Reset mid-operation: all in-flight beats are discarded. No output beat follows deassertion until a new beat is accepted.
- No combinational path from in_valid to out_valid. in_ready depends only on out_valid and out_ready.

Test Plan:
- Basic: sum=1000, a=400 → b=600, underflow=0, overflow=0; out_valid exactly 5 cycles after accept.
- Slice-boundary borrow: sum=2^20, a=1 → b=0xFFFFF, no flags. Then sum=2^60, a=1 → b=2^60−1.
- Flags:
  - sum=3, a=5 → b=2^80−2, underflow=1.
  - sum=2^80+5, a=2 → b=3, overflow=1.
  - sum=2^80+1, a=2 → b=2^80−1, no flags.
- Backpressure: stream 10 random (a, b) pairs with sum = a+b, and toggle out_ready randomly.
  - All 10 b values are returned in order with no flags.
  - Outputs are stable during stalls, and in_ready = 0 exactly when out_valid && !out_ready.
- Throughput: continuous in_valid with out_ready=1 → one result per cycle after 5-cycle fill, no gaps.
- Reset mid-flight: accept 3 beats, pull rst_n low for 1 cycle before any emerges → out_valid stays 0 thereafter until new input; flags and b read 0.
